// File: rtl/nco_qsin_iq.sv
// Quadrature NCO: phase accumulator feeding a two-port quarter-sine ROM whose
// quadrant-folded reads are rebuilt into signed full-wave sin/cos samples.
module nco_qsin_iq #(
   parameter int PW    = 32,
   parameter int ABITS = 8,
   parameter int DW    = 16,
   parameter int SCALE = 2**(DW-1)-1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          sync,
   input  logic [PW-1:0] ftw,
   input  logic [PW-1:0] phase_off,
   output logic [DW-1:0] sin_out,
   output logic [DW-1:0] cos_out,
   output logic          valid
);

   // valid is a pure qualifier with no back-pressure: every cycle it is high,
   // sin_out/cos_out carry a fresh sample that the consumer must take.

   localparam int              SIZE    = 2**ABITS;
   localparam int              FB      = 28;
   localparam longint          PI_Q    = 64'sd843314857;
   localparam logic [DW-1:0]   SCALE_V = DW'(SCALE);

   // Elaboration-time sine in Q28 fixed point (odd Taylor series), rounded
   // to nearest after scaling; all table entries are non-negative.
   function automatic logic [DW-1:0] rom_val(input int i);
      longint x, x2, term, sum, amp;
      x    = (PI_Q * longint'(i)) / longint'(2 * SIZE);
      x2   = (x * x) >>> FB;
      term = x;
      sum  = x;
      for (int k = 1; k < 12; k++) begin
         term = -(((term * x2) >>> FB) / longint'((2 * k) * (2 * k + 1)));
         sum  = sum + term;
      end
      amp = (longint'(SCALE) * sum + (longint'(1) <<< (FB - 1))) >>> FB;
      return DW'(amp);
   endfunction

   logic [DW-1:0] w_rom [SIZE];

   for (genvar g = 0; g < SIZE; g++) begin : g_rom
      localparam logic [DW-1:0] ROM_V = rom_val(g);
      assign w_rom[g] = ROM_V;
   end

   // Phase accumulator and quadrant decode
   logic [PW-1:0]    r_acc;
   logic [PW-1:0]    w_acc_eff;
   logic [PW-1:0]    w_phase;
   logic [1:0]       w_q_s;
   logic [1:0]       w_q_c;
   logic [ABITS-1:0] w_idx;
   logic [ABITS-1:0] w_idx_mir;
   logic             w_idx_zero;

   assign w_acc_eff  = sync ? '0 : r_acc;
   assign w_phase    = w_acc_eff + phase_off;
   assign w_q_s      = w_phase[PW-1:PW-2];
   assign w_q_c      = w_q_s + 2'd1;
   assign w_idx      = w_phase[PW-3 -: ABITS];
   assign w_idx_mir  = '0 - w_idx;
   assign w_idx_zero = (w_idx == '0);

   if (PW > ABITS + 2) begin : g_lsb
      logic w_unused_lsb;
      assign w_unused_lsb = ^w_phase[PW-3-ABITS:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
      end else if (en) begin
         r_acc <= w_acc_eff + ftw;
      end else begin
         r_acc <= w_acc_eff;
      end
   end

   // S1: ROM addresses plus the peak-substitute and negate flags per channel
   logic             r1_vld;
   logic [ABITS-1:0] r1_addr_s;
   logic [ABITS-1:0] r1_addr_c;
   logic             r1_scl_s;
   logic             r1_scl_c;
   logic             r1_neg_s;
   logic             r1_neg_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         r1_vld    <= 1'b0;
         r1_addr_s <= '0;
         r1_addr_c <= '0;
         r1_scl_s  <= 1'b0;
         r1_scl_c  <= 1'b0;
         r1_neg_s  <= 1'b0;
         r1_neg_c  <= 1'b0;
      end else begin
         r1_vld    <= en;
         r1_addr_s <= w_q_s[0] ? w_idx_mir : w_idx;
         r1_addr_c <= w_q_c[0] ? w_idx_mir : w_idx;
         r1_scl_s  <= w_q_s[0] & w_idx_zero;
         r1_scl_c  <= w_q_c[0] & w_idx_zero;
         r1_neg_s  <= w_q_s[1];
         r1_neg_c  <= w_q_c[1];
      end
   end

   // S2: registered two-port ROM read (port 1 sine, port 2 cosine)
   logic          r2_vld;
   logic [DW-1:0] r2_rom_s;
   logic [DW-1:0] r2_rom_c;
   logic          r2_scl_s;
   logic          r2_scl_c;
   logic          r2_neg_s;
   logic          r2_neg_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         r2_vld   <= 1'b0;
         r2_rom_s <= '0;
         r2_rom_c <= '0;
         r2_scl_s <= 1'b0;
         r2_scl_c <= 1'b0;
         r2_neg_s <= 1'b0;
         r2_neg_c <= 1'b0;
      end else begin
         r2_vld   <= r1_vld;
         r2_rom_s <= w_rom[r1_addr_s];
         r2_rom_c <= w_rom[r1_addr_c];
         r2_scl_s <= r1_scl_s;
         r2_scl_c <= r1_scl_c;
         r2_neg_s <= r1_neg_s;
         r2_neg_c <= r1_neg_c;
      end
   end

   // S3: magnitude select and sign restore; outputs hold when no sample
   logic [DW-1:0] w_mag_s;
   logic [DW-1:0] w_mag_c;
   logic [DW-1:0] w_sin;
   logic [DW-1:0] w_cos;
   logic [DW-1:0] r_sin;
   logic [DW-1:0] r_cos;
   logic          r_valid;

   assign w_mag_s = r2_scl_s ? SCALE_V : r2_rom_s;
   assign w_mag_c = r2_scl_c ? SCALE_V : r2_rom_c;
   assign w_sin   = r2_neg_s ? ('0 - w_mag_s) : w_mag_s;
   assign w_cos   = r2_neg_c ? ('0 - w_mag_c) : w_mag_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sin   <= '0;
         r_cos   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= r2_vld;
         if (r2_vld) begin
            r_sin <= w_sin;
            r_cos <= w_cos;
         end
      end
   end

   assign sin_out = r_sin;
   assign cos_out = r_cos;
   assign valid   = r_valid;

endmodule

// File: tb/tb_nco_qsin_iq.sv
// Bench for nco_qsin_iq (PW=16, ABITS=4, DW=8, SCALE=127): trig-based model
// with a due-cycle expectation queue, plus directed literal sample checks.
module tb_nco_qsin_iq;

   localparam real PI = 3.14159265358979323846;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        sync = 1'b0;
   logic [15:0] ftw = '0;
   logic [15:0] phase_off = '0;
   logic [7:0]  sin_out;
   logic [7:0]  cos_out;
   logic        valid;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {int due; int s; int c;} exp_t;
   typedef struct {int s; int c;} smp_t;
   exp_t exp_q[$];
   smp_t got_q[$];

   logic [15:0] m_acc = '0;
   logic [15:0] m_aeff;
   logic        m_valid = 1'b0;
   int          m_sin = 0;
   int          m_cos = 0;
   int          m_s;
   int          m_c;
   exp_t        m_e;

   nco_qsin_iq #(.PW(16), .ABITS(4), .DW(8), .SCALE(127)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .sync      (sync),
      .ftw       (ftw),
      .phase_off (phase_off),
      .sin_out   (sin_out),
      .cos_out   (cos_out),
      .valid     (valid)
   );

   always #5 clk = ~clk;

   function automatic int rnd(input real x);
      if (x >= 0.0) return $rtoi(x + 0.5);
      return -$rtoi(-x + 0.5);
   endfunction

   // Ideal quadrature sample at the 6-bit truncated phase (64 steps per turn)
   task automatic ref_iq(input logic [15:0] p, output int s, output int c);
      real th;
      th = 2.0 * PI * real'(int'(p >> 10)) / 64.0;
      s  = rnd(127.0 * $sin(th));
      c  = rnd(127.0 * $cos(th));
   endtask

   task automatic chk(input string nm, input logic signed [31:0] act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic chk_smp(input string nm, input int k, input int s, input int c);
      if (k >= got_q.size()) begin
         total++;
         bad++;
         $display("FAIL %s sample %0d missing, have %0d samples", nm, k, got_q.size());
      end else begin
         chk({nm, "_sin"}, got_q[k].s, s);
         chk({nm, "_cos"}, got_q[k].c, c);
      end
   endtask

   task automatic drv(input logic r, input logic e, input logic s,
                      input logic [15:0] f, input logic [15:0] p);
      rst = r; en = e; sync = s; ftw = f; phase_off = p;
      @(posedge clk);
      #2;
   endtask

   // Model: issue at a sampled edge, visible after the edge two later
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         exp_q.delete();
         m_acc   = '0;
         m_valid = 1'b0;
         m_sin   = 0;
         m_cos   = 0;
      end else begin
         m_aeff = sync ? 16'h0000 : m_acc;
         if (en) begin
            ref_iq(m_aeff + phase_off, m_s, m_c);
            exp_q.push_back('{cyc + 2, m_s, m_c});
         end
         m_acc = en ? (m_aeff + ftw) : m_aeff;
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            m_e     = exp_q.pop_front();
            m_valid = 1'b1;
            m_sin   = m_e.s;
            m_cos   = m_e.c;
         end else begin
            m_valid = 1'b0;
         end
      end
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("cyc_valid", valid, int'(m_valid));
         chk("cyc_sin", $signed(sin_out), m_sin);
         chk("cyc_cos", $signed(cos_out), m_cos);
         if (valid === 1'b1) got_q.push_back('{int'($signed(sin_out)), int'($signed(cos_out))});
      end
   end

   initial begin
      int s, c;
      ref_iq(16'h1000, s, c); chk("model_1000_sin", s, 49);  chk("model_1000_cos", c, 117);
      ref_iq(16'hF000, s, c); chk("model_F000_sin", s, -49); chk("model_F000_cos", c, 117);
      ref_iq(16'h2000, s, c); chk("model_2000_sin", s, 90);  chk("model_2000_cos", c, 90);
      ref_iq(16'hC000, s, c); chk("model_C000_sin", s, -127); chk("model_C000_cos", c, 0);

      // reset then idle
      drv(1, 0, 0, 16'h0000, 16'h0000);
      drv(1, 0, 0, 16'h0000, 16'h0000);
      for (int i = 0; i < 4; i++) drv(0, 0, 0, 16'h0000, 16'h0000);
      chk("t1_valid", valid, 0);
      chk("t1_sin", $signed(sin_out), 0);
      chk("t1_cos", $signed(cos_out), 0);

      // full turn at ftw=0x1000
      drv(0, 0, 1, 16'h1000, 16'h0000);
      got_q.delete();
      for (int i = 0; i < 17; i++) drv(0, 1, 0, 16'h1000, 16'h0000);
      for (int i = 0; i < 3; i++) drv(0, 0, 0, 16'h1000, 16'h0000);
      chk("t2_count", got_q.size(), 17);
      chk_smp("t2_s0", 0, 0, 127);
      chk_smp("t2_s1", 1, 49, 117);
      chk_smp("t2_s4", 4, 127, 0);
      chk_smp("t2_s8", 8, 0, -127);
      chk_smp("t2_s12", 12, -127, 0);
      chk_smp("t2_s16", 16, 0, 127);

      // static phase offsets
      got_q.delete();
      drv(0, 1, 1, 16'h0000, 16'h4000);
      for (int i = 0; i < 4; i++) drv(0, 1, 0, 16'h0000, 16'h4000);
      for (int i = 0; i < 5; i++) drv(0, 1, 0, 16'h0000, 16'hC000);
      for (int i = 0; i < 3; i++) drv(0, 0, 0, 16'h0000, 16'hC000);
      chk("t3_count", got_q.size(), 10);
      chk_smp("t3_s0", 0, 127, 0);
      chk_smp("t3_s4", 4, 127, 0);
      chk_smp("t3_s5", 5, -127, 0);
      chk_smp("t3_s9", 9, -127, 0);

      // reverse rotation
      drv(0, 0, 1, 16'hF000, 16'h0000);
      got_q.delete();
      for (int i = 0; i < 5; i++) drv(0, 1, 0, 16'hF000, 16'h0000);
      for (int i = 0; i < 3; i++) drv(0, 0, 0, 16'hF000, 16'h0000);
      chk("t4_count", got_q.size(), 5);
      chk_smp("t4_s0", 0, 0, 127);
      chk_smp("t4_s1", 1, -49, 117);
      chk_smp("t4_s4", 4, -127, 0);

      // gapped enable
      drv(0, 0, 1, 16'h1000, 16'h0000);
      got_q.delete();
      drv(0, 1, 0, 16'h1000, 16'h0000);
      drv(0, 0, 0, 16'h1000, 16'h0000);
      drv(0, 1, 0, 16'h1000, 16'h0000);
      drv(0, 1, 0, 16'h1000, 16'h0000);
      drv(0, 0, 0, 16'h1000, 16'h0000);
      for (int i = 0; i < 3; i++) drv(0, 0, 0, 16'h1000, 16'h0000);
      chk("t5_count", got_q.size(), 3);
      chk_smp("t5_s0", 0, 0, 127);
      chk_smp("t5_s1", 1, 49, 117);
      chk_smp("t5_s2", 2, 90, 90);

      // mid-stream sync, then reset while valid is high
      got_q.delete();
      for (int i = 0; i < 5; i++) drv(0, 1, 0, 16'h1000, 16'h0000);
      drv(0, 1, 1, 16'h1000, 16'h0000);
      for (int i = 0; i < 3; i++) drv(0, 1, 0, 16'h1000, 16'h0000);
      drv(1, 1, 0, 16'h1000, 16'h0000);
      chk("t6_rst_valid", valid, 0);
      chk("t6_rst_sin", $signed(sin_out), 0);
      chk("t6_rst_cos", $signed(cos_out), 0);
      chk("t6_count_at_rst", got_q.size(), 7);
      chk_smp("t6_sync", 5, 0, 127);
      chk_smp("t6_after_sync", 6, 49, 117);
      for (int i = 0; i < 5; i++) drv(0, 0, 0, 16'h1000, 16'h0000);
      chk("t6_no_stale", got_q.size(), 7);
      for (int i = 0; i < 2; i++) drv(0, 1, 0, 16'h1000, 16'h0000);
      for (int i = 0; i < 3; i++) drv(0, 0, 0, 16'h1000, 16'h0000);
      chk("t6_count_restart", got_q.size(), 9);
      chk_smp("t6_restart_s0", 7, 0, 127);
      chk_smp("t6_restart_s1", 8, 49, 117);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
